act_pwl_pipe: RTL and testbench

- Multi-lane, pipelined piecewise-linear activation unit for the RNN datapath.
- Successor to the single-lane combinational fixed-point tanh.
- Adds parametrised width, fraction bits and lane count, a per-transaction tanh/sigmoid mode, a 3-stage pipeline, and valid/ready backpressure.
- Sits between the MAC accumulator output and the hidden-state buffer.

---
 rtl/act_pwl_pipe.sv | 263 ++++++++++++++++++++++++++
 tb/tb_act_pwl_pipe.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/act_pwl_pipe.sv
`default_nettype none
// ============================================================================
// Module      : act_pwl_pipe
// Description : Multi-lane, 3-stage pipelined piecewise-linear tanh/sigmoid
//               activation with valid/ready backpressure. Lane k of a beat
//               lives at bits [k*WIDTH +: WIDTH]; mode and last travel with
//               the beat. Optional saturated-lane counter is enabled by
//               defining the macro ACT_SAT_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module act_pwl_pipe #(
  parameter int WIDTH = 16,
  parameter int FRAC  = 12,
  parameter int LANES = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [LANES*WIDTH-1:0]   in_data,
  input  logic                     in_mode,
  input  logic                     in_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [LANES*WIDTH-1:0]   out_data,
  output logic                     out_last
`ifdef ACT_SAT_CNT_EN
  ,
  input  logic                     sat_cnt_clr,
  output logic [31:0]              sat_cnt
`endif
);

  // Fixed-point constants in Q(FRAC); WIDTH-FRAC >= 3 keeps 2.5 representable
  // and FRAC >= 4 keeps 0.6875 exact.
  localparam logic [WIDTH-1:0] C_ONE      = {{(WIDTH-FRAC-1){1'b0}}, 1'b1, {FRAC{1'b0}}};
  localparam logic [WIDTH-1:0] C_HALF     = C_ONE >> 1;
  localparam logic [WIDTH-1:0] C_QUART    = C_ONE >> 2;
  localparam logic [WIDTH-1:0] C_ONE_HALF = C_ONE + C_HALF;
  localparam logic [WIDTH-1:0] C_TWO_HALF = (C_ONE << 1) + C_HALF;
  localparam logic [WIDTH-1:0] C_P6875    = C_HALF + (C_ONE >> 3) + (C_ONE >> 4);
  localparam logic [WIDTH-1:0] C_MAX_POS  = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] C_MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  // Global advance: every stage shifts together whenever the output slot
  // is empty or being consumed.
  logic adv;

  // Stage 1 registers: sign and (pre-scaled) magnitude per lane.
  logic                         s1_valid_q, s1_valid_d;
  logic                         s1_mode_q,  s1_mode_d;
  logic                         s1_last_q,  s1_last_d;
  logic [LANES-1:0]             s1_sign_q,  s1_sign_d;
  logic [LANES-1:0][WIDTH-1:0]  s1_mag_q,   s1_mag_d;

  // Stage 2 registers: unsigned segment result t per lane.
  logic                         s2_valid_q, s2_valid_d;
  logic                         s2_mode_q,  s2_mode_d;
  logic                         s2_last_q,  s2_last_d;
  logic [LANES-1:0]             s2_sign_q,  s2_sign_d;
  logic [LANES-1:0][WIDTH-1:0]  s2_t_q,     s2_t_d;

  // Stage 3 (output) registers.
  logic                         out_valid_q, out_valid_d;
  logic                         out_last_q,  out_last_d;
  logic [LANES*WIDTH-1:0]       out_data_q,  out_data_d;

  // Combinational per-stage datapath results.
  logic [LANES-1:0]             w_sign1;
  logic [LANES-1:0][WIDTH-1:0]  w_mag1;
  logic [LANES-1:0][WIDTH-1:0]  w_t2;
  logic [LANES-1:0][WIDTH-1:0]  w_y3;
  logic [LANES-1:0][WIDTH-1:0]  w_h3;

  assign adv       = !out_valid_q || out_ready;
  assign in_ready  = adv;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_data  = out_data_q;

  // Stage 1 datapath: split sign/magnitude, saturate the most negative code,
  // halve the magnitude for sigmoid (sigma(x) = 0.5 + 0.5*tanh(x/2)).
  always_comb begin
    w_sign1 = '0;
    w_mag1  = '0;
    for (int k = 0; k < LANES; k++) begin
      w_sign1[k] = in_data[k*WIDTH + WIDTH - 1];
      if (in_data[k*WIDTH +: WIDTH] == C_MOST_NEG) begin
        w_mag1[k] = C_MAX_POS;
      end else if (w_sign1[k]) begin
        w_mag1[k] = -in_data[k*WIDTH +: WIDTH];
      end else begin
        w_mag1[k] = in_data[k*WIDTH +: WIDTH];
      end
      if (in_mode) begin
        w_mag1[k] = w_mag1[k] >> 1;
      end
    end
  end

  // Stage 2 datapath: five-segment piecewise-linear approximation of tanh(m).
  always_comb begin
    w_t2 = '0;
    for (int k = 0; k < LANES; k++) begin
      if (s1_mag_q[k] < C_HALF) begin
        w_t2[k] = s1_mag_q[k];
      end else if (s1_mag_q[k] < C_ONE) begin
        w_t2[k] = C_QUART + (s1_mag_q[k] >> 1);
      end else if (s1_mag_q[k] < C_ONE_HALF) begin
        w_t2[k] = C_HALF + (s1_mag_q[k] >> 2);
      end else if (s1_mag_q[k] < C_TWO_HALF) begin
        w_t2[k] = C_P6875 + (s1_mag_q[k] >> 3);
      end else begin
        w_t2[k] = C_ONE;
      end
    end
  end

  // Stage 3 datapath: restore sign (tanh) or map to 0.5 +/- t/2 (sigmoid).
  always_comb begin
    w_y3 = '0;
    w_h3 = '0;
    for (int k = 0; k < LANES; k++) begin
      w_h3[k] = s2_t_q[k] >> 1;
      if (!s2_mode_q) begin
        w_y3[k] = s2_sign_q[k] ? -s2_t_q[k] : s2_t_q[k];
      end else begin
        w_y3[k] = s2_sign_q[k] ? (C_HALF - w_h3[k]) : (C_HALF + w_h3[k]);
      end
    end
  end

  // Pipeline next-state: hold everything unless advancing; data registers
  // only load behind a valid beat so bubbles do not toggle the datapath.
  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_mode_d   = s1_mode_q;
    s1_last_d   = s1_last_q;
    s1_sign_d   = s1_sign_q;
    s1_mag_d    = s1_mag_q;
    s2_valid_d  = s2_valid_q;
    s2_mode_d   = s2_mode_q;
    s2_last_d   = s2_last_q;
    s2_sign_d   = s2_sign_q;
    s2_t_d      = s2_t_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_data_d  = out_data_q;
    if (adv) begin
      s1_valid_d  = in_valid;
      s2_valid_d  = s1_valid_q;
      out_valid_d = s2_valid_q;
      if (in_valid) begin
        s1_mode_d = in_mode;
        s1_last_d = in_last;
        s1_sign_d = w_sign1;
        s1_mag_d  = w_mag1;
      end
      if (s1_valid_q) begin
        s2_mode_d = s1_mode_q;
        s2_last_d = s1_last_q;
        s2_sign_d = s1_sign_q;
        s2_t_d    = w_t2;
      end
      if (s2_valid_q) begin
        out_last_d = s2_last_q;
        out_data_d = w_y3;
      end
    end
  end

  // Pipeline state registers; asynchronous reset discards in-flight beats.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_mode_q   <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_sign_q   <= '0;
      s1_mag_q    <= '0;
      s2_valid_q  <= 1'b0;
      s2_mode_q   <= 1'b0;
      s2_last_q   <= 1'b0;
      s2_sign_q   <= '0;
      s2_t_q      <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_mode_q   <= s1_mode_d;
      s1_last_q   <= s1_last_d;
      s1_sign_q   <= s1_sign_d;
      s1_mag_q    <= s1_mag_d;
      s2_valid_q  <= s2_valid_d;
      s2_mode_q   <= s2_mode_d;
      s2_last_q   <= s2_last_d;
      s2_sign_q   <= s2_sign_d;
      s2_t_q      <= s2_t_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
    end
  end

`ifdef ACT_SAT_CNT_EN
  localparam int CNT_W = $clog2(LANES + 1);

  // Saturation flags follow their beat through stages 2 and 3 so the count
  // is credited only when the beat actually retires.
  logic [LANES-1:0]  s2_sat_q,    s2_sat_d;
  logic [CNT_W-1:0]  out_nsat_q,  out_nsat_d;
  logic [31:0]       sat_cnt_q,   sat_cnt_d;
  logic [LANES-1:0]  w_sat2;
  logic [CNT_W-1:0]  w_nsat3;
  logic [32:0]       w_sum;

  assign sat_cnt = sat_cnt_q;

  // Per-beat saturated-lane flags and population count.
  always_comb begin
    w_sat2  = '0;
    w_nsat3 = '0;
    for (int k = 0; k < LANES; k++) begin
      w_sat2[k] = (s1_mag_q[k] >= C_TWO_HALF);
      w_nsat3   = w_nsat3 + CNT_W'(s2_sat_q[k]);
    end
  end

  // Counter next-state: clear dominates; the add clamps at all-ones.
  always_comb begin
    s2_sat_d   = s2_sat_q;
    out_nsat_d = out_nsat_q;
    sat_cnt_d  = sat_cnt_q;
    w_sum      = {1'b0, sat_cnt_q} + 33'(out_nsat_q);
    if (adv && s1_valid_q) begin
      s2_sat_d = w_sat2;
    end
    if (adv && s2_valid_q) begin
      out_nsat_d = w_nsat3;
    end
    if (sat_cnt_clr) begin
      sat_cnt_d = '0;
    end else if (out_valid_q && out_ready) begin
      sat_cnt_d = w_sum[32] ? 32'hFFFF_FFFF : w_sum[31:0];
    end
  end

  // Counter state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_sat_q   <= '0;
      out_nsat_q <= '0;
      sat_cnt_q  <= '0;
    end else begin
      s2_sat_q   <= s2_sat_d;
      out_nsat_q <= out_nsat_d;
      sat_cnt_q  <= sat_cnt_d;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_act_pwl_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_act_pwl_pipe
// Description : Directed self-checking bench for act_pwl_pipe (Q4.12, 4 lanes)
//               covering reset, tanh/sigmoid points, segment boundaries,
//               backpressure, mid-stream reset and the optional counter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_act_pwl_pipe;

  localparam int WIDTH = 16;
  localparam int FRAC  = 12;
  localparam int LANES = 4;

  logic        clk       = 1'b0;
  logic        rst       = 1'b1;
  logic        in_valid  = 1'b0;
  logic        in_mode   = 1'b0;
  logic        in_last   = 1'b0;
  logic        out_ready = 1'b1;
  logic [63:0] in_data   = '0;
  logic        in_ready;
  logic        out_valid;
  logic        out_last;
  logic [63:0] out_data;
`ifdef ACT_SAT_CNT_EN
  logic        sat_cnt_clr = 1'b0;
  logic [31:0] sat_cnt;
`endif

  int checks = 0;
  int errors = 0;

  // Hand-computed vectors (lane 3 leftmost).
  localparam logic [63:0] TANH_IN  = 64'h3000_E000_1000_0400;
  localparam logic [63:0] TANH_EXP = 64'h1000_F100_0C00_0400;
  localparam logic [63:0] SIG_IN   = 64'h7FFF_E000_2000_0000;
  localparam logic [63:0] SIG_EXP  = 64'h1000_0200_0E00_0800;
  localparam logic [63:0] BND_IN   = 64'h2800_27FF_1800_0800;
  localparam logic [63:0] BND_EXP  = 64'h1000_0FFF_0E00_0800;
  localparam logic [63:0] NEG_IN   = 64'h0000_0000_0000_8000;
  localparam logic [63:0] NEG_EXP  = 64'h0000_0000_0000_F000;

  act_pwl_pipe #(.WIDTH(WIDTH), .FRAC(FRAC), .LANES(LANES)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_mode   (in_mode),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last)
`ifdef ACT_SAT_CNT_EN
    ,
    .sat_cnt_clr (sat_cnt_clr),
    .sat_cnt     (sat_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next falling edge.
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Rotate a 4-lane word by n lanes.
  function automatic logic [63:0] rot(input logic [63:0] v, input int n);
    logic [63:0] r;
    r = v;
    for (int i = 0; i < n; i++) r = {r[15:0], r[63:16]};
    return r;
  endfunction

  // One isolated beat: checks acceptance, 3-cycle latency and the result.
  task automatic single(input string tag, input logic [63:0] d, input logic m,
                        input logic [63:0] e);
    in_valid = 1'b1;
    in_data  = d;
    in_mode  = m;
    in_last  = 1'b0;
    chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0;
    chk({tag, "_valid_c1"}, 64'(out_valid), 64'd0);
    step();
    chk({tag, "_valid_c2"}, 64'(out_valid), 64'd0);
    step();
    chk({tag, "_valid_c3"}, 64'(out_valid), 64'd1);
    chk({tag, "_data"}, out_data, e);
    chk({tag, "_last"}, 64'(out_last), 64'd0);
    step();
    chk({tag, "_valid_c4"}, 64'(out_valid), 64'd0);
  endtask

  logic [63:0] bp_in  [10];
  logic [63:0] bp_exp [10];
  logic [63:0] held;
  int          tx;
  int          rx;

  initial begin
    // Reset behaviour
    step();
    step();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", out_data, 64'd0);
    chk("rst_out_last", 64'(out_last), 64'd0);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    step();

    // Directed points
    single("tanh", TANH_IN, 1'b0, TANH_EXP);
    single("sigmoid", SIG_IN, 1'b1, SIG_EXP);
    single("extreme_neg", NEG_IN, 1'b0, NEG_EXP);
    single("boundaries", BND_IN, 1'b0, BND_EXP);

    // Backpressure stream: alternating modes, 4-cycle stall mid-stream
    for (int i = 0; i < 10; i++) begin
      bp_in[i]  = rot((i % 2 == 0) ? TANH_IN  : SIG_IN,  i % 4);
      bp_exp[i] = rot((i % 2 == 0) ? TANH_EXP : SIG_EXP, i % 4);
    end
    tx = 0;
    rx = 0;
    held = '0;
    for (int cyc = 0; cyc < 60 && rx < 10; cyc++) begin
      out_ready = !(cyc >= 6 && cyc <= 9);
      #1;
      if (cyc >= 6 && cyc <= 9) begin
        chk("bp_stall_valid", 64'(out_valid), 64'd1);
        chk("bp_stall_in_ready", 64'(in_ready), 64'd0);
        if (cyc == 6) held = out_data;
        else chk("bp_stall_hold", out_data, held);
      end
      if (out_valid && out_ready) begin
        chk($sformatf("bp_data_%0d", rx), out_data, bp_exp[rx]);
        chk($sformatf("bp_last_%0d", rx), 64'(out_last), 64'(rx == 9));
        rx++;
      end
      if (tx < 10) begin
        in_valid = 1'b1;
        in_data  = bp_in[tx];
        in_mode  = tx[0];
        in_last  = (tx == 9);
        if (in_ready) tx++;
      end else begin
        in_valid = 1'b0;
        in_last  = 1'b0;
      end
      step();
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    chk("bp_beat_count", 64'(rx), 64'd10);
    step();
    chk("bp_no_extra", 64'(out_valid), 64'd0);

    // Reset with three beats in flight
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = TANH_IN;
      in_mode  = 1'b0;
      step();
    end
    in_valid = 1'b0;
    chk("mid_rst_pre_valid", 64'(out_valid), 64'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid_now", 64'(out_valid), 64'd0);
    chk("mid_rst_data_now", out_data, 64'd0);
    step();
    rst = 1'b0;
    step();
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("mid_rst_no_stale_%0d", i), 64'(out_valid), 64'd0);
      step();
    end

`ifdef ACT_SAT_CNT_EN
    // Saturated-lane counter: three beats with two saturating lanes each
    chk("sat_cnt_reset", 64'(sat_cnt), 64'd0);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = 64'h0000_3000_0000_D000;
      in_mode  = 1'b0;
      step();
    end
    in_valid = 1'b0;
    repeat (5) step();
    chk("sat_cnt_six", 64'(sat_cnt), 64'd6);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    chk("sat_clr_beat_valid", 64'(out_valid), 64'd1);
    sat_cnt_clr = 1'b1;
    step();
    sat_cnt_clr = 1'b0;
    chk("sat_cnt_clear_wins", 64'(sat_cnt), 64'd0);
    step();
    chk("sat_cnt_stays_clear", 64'(sat_cnt), 64'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
